// File: rtl/wtr_control_unit_pkg.sv
`default_nettype none
//============================================================================
// Module   : wtr_cu_pkg
// Purpose  : Shared definitions for the WTR control unit: opcodes, register
//            codes, ALU operation codes and the sequencer state encoding.
// Config   : WTR_SINGLE_STEP_EN adds the STEP state.
// Revision : 1.0 - initial release
//============================================================================
package wtr_cu_pkg;

   // Opcodes (instr[7:4]); undefined opcodes execute as NOP
   localparam logic [3:0] c_OP_NOP   = 4'h0;
   localparam logic [3:0] c_OP_LDR   = 4'h1;
   localparam logic [3:0] c_OP_STR   = 4'h2;
   localparam logic [3:0] c_OP_MVR   = 4'h3;
   localparam logic [3:0] c_OP_MVT   = 4'h4;
   localparam logic [3:0] c_OP_ADD   = 4'h5;
   localparam logic [3:0] c_OP_MUL   = 4'h6;
   localparam logic [3:0] c_OP_INC   = 4'h7;
   localparam logic [3:0] c_OP_JMPNZ = 4'h8;
   localparam logic [3:0] c_OP_END   = 4'hF;

   // Register codes shared by WTR_sel and bus_sel; 0 selects nothing
   localparam logic [4:0] c_REG_NONE = 5'd0;
   localparam logic [4:0] c_REG_N    = 5'd1;
   localparam logic [4:0] c_REG_M    = 5'd2;
   localparam logic [4:0] c_REG_P    = 5'd3;
   localparam logic [4:0] c_REG_R1   = 5'd4;
   localparam logic [4:0] c_REG_ROW  = 5'd5;
   localparam logic [4:0] c_REG_COL  = 5'd6;
   localparam logic [4:0] c_REG_CURR = 5'd7;
   localparam logic [4:0] c_REG_SUM  = 5'd8;
   localparam logic [4:0] c_REG_STA  = 5'd9;
   localparam logic [4:0] c_REG_STB  = 5'd10;
   localparam logic [4:0] c_REG_STC  = 5'd11;
   localparam logic [4:0] c_REG_A    = 5'd12;
   localparam logic [4:0] c_REG_B    = 5'd13;
   localparam logic [4:0] c_REG_R    = 5'd14;

   // ALU operation codes
   localparam logic [2:0] c_ALU_PASS = 3'd0;
   localparam logic [2:0] c_ALU_ADD  = 3'd1;
   localparam logic [2:0] c_ALU_MUL  = 3'd2;
   localparam logic [2:0] c_ALU_INC  = 3'd3;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_LATCH  = 4'd2,
      ST_EXEC   = 4'd3,
      ST_MEMW   = 4'd4,
      ST_WB     = 4'd5,
      ST_TFETCH = 4'd6,
      ST_TLATCH = 4'd7,
      ST_HALT   = 4'd8
`ifdef WTR_SINGLE_STEP_EN
      ,
      ST_STEP   = 4'd9
`endif
   } state_t;

   // State entered when an instruction retires: single-step parks in STEP,
   // otherwise the next fetch issues immediately.
`ifdef WTR_SINGLE_STEP_EN
   localparam state_t c_ST_RETIRE = ST_STEP;
`else
   localparam state_t c_ST_RETIRE = ST_FETCH;
`endif

   // Opcodes LDR..INC carry a register operand; codes 0 and 15 name no register.
   function automatic logic rf_is_bad(input logic [3:0] op, input logic [3:0] rf);
      return (op >= c_OP_LDR) && (op <= c_OP_INC) && ((rf == 4'h0) || (rf == 4'hF));
   endfunction

endpackage
`default_nettype wire

// File: rtl/wtr_control_unit_if.sv
`default_nettype none
//============================================================================
// Module   : wtr_control_unit_if
// Purpose  : Bundle between the control unit and its environment
//            (instruction RAM, ALU flag, WTR decoder, bus mux, data memory).
// Ports    : master = control unit side, slave = environment side.
//            start, z_flag, instr (and step) flow into the control unit;
//            iram_addr, WTR_sel, WTR_en, bus_sel, alu_op, mem_read,
//            mem_write, done, illegal flow out of it.
// Config   : WTR_SINGLE_STEP_EN adds the step signal.
// Revision : 1.0 - initial release
//============================================================================
interface wtr_control_unit_if #(
   parameter int IADDR_W = 8
);
   logic               start;
   logic               z_flag;
   logic [7:0]         instr;
`ifdef WTR_SINGLE_STEP_EN
   logic               step;
`endif
   logic [IADDR_W-1:0] iram_addr;
   logic [4:0]         WTR_sel;
   logic               WTR_en;
   logic [4:0]         bus_sel;
   logic [2:0]         alu_op;
   logic               mem_read;
   logic               mem_write;
   logic               done;
   logic               illegal;

   modport master (
      input  start,
      input  z_flag,
      input  instr,
`ifdef WTR_SINGLE_STEP_EN
      input  step,
`endif
      output iram_addr,
      output WTR_sel,
      output WTR_en,
      output bus_sel,
      output alu_op,
      output mem_read,
      output mem_write,
      output done,
      output illegal
   );

   modport slave (
      output start,
      output z_flag,
      output instr,
`ifdef WTR_SINGLE_STEP_EN
      output step,
`endif
      input  iram_addr,
      input  WTR_sel,
      input  WTR_en,
      input  bus_sel,
      input  alu_op,
      input  mem_read,
      input  mem_write,
      input  done,
      input  illegal
   );
endinterface
`default_nettype wire

// File: rtl/wtr_control_unit_decode.sv
`default_nettype none
//============================================================================
// Module   : wtr_cu_decode
// Purpose  : Combinational control-word decoder. Maps the sequencer state
//            and the latched instruction onto the datapath controls.
// Ports    : state       - current sequencer state
//            ir          - latched instruction
//            wtr_sel/wtr_en, bus_sel, alu_op, mem_read, mem_write, done
//                        - datapath control word
//            illegal_hit - EXEC of an instruction with a bad register field
// Revision : 1.0 - initial release
//============================================================================
module wtr_cu_decode
   import wtr_cu_pkg::*;
(
   input  state_t     state,
   input  logic [7:0] ir,
   output logic [4:0] wtr_sel,
   output logic       wtr_en,
   output logic [4:0] bus_sel,
   output logic [2:0] alu_op,
   output logic       mem_read,
   output logic       mem_write,
   output logic       done,
   output logic       illegal_hit
);

   logic [3:0] w_op;
   logic [4:0] w_rf;
   logic       w_bad;

   assign w_op  = ir[7:4];
   assign w_rf  = {1'b0, ir[3:0]};
   assign w_bad = rf_is_bad(ir[7:4], ir[3:0]);

   always_comb begin
      wtr_sel     = c_REG_NONE;
      wtr_en      = 1'b0;
      bus_sel     = c_REG_NONE;
      alu_op      = c_ALU_PASS;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      done        = 1'b0;
      illegal_hit = 1'b0;
      case (state)
         ST_EXEC: begin
            // A bad register field turns the whole instruction into a NOP
            if (w_bad) begin
               illegal_hit = 1'b1;
            end else begin
               case (w_op)
                  c_OP_MVR, c_OP_ADD, c_OP_MUL: begin
                     bus_sel = w_rf;
                     wtr_sel = c_REG_R;
                     wtr_en  = 1'b1;
                     alu_op  = (w_op == c_OP_ADD) ? c_ALU_ADD :
                               (w_op == c_OP_MUL) ? c_ALU_MUL : c_ALU_PASS;
                  end
                  c_OP_MVT: begin
                     bus_sel = c_REG_R;
                     wtr_sel = w_rf;
                     wtr_en  = 1'b1;
                  end
                  c_OP_INC: begin
                     bus_sel = w_rf;
                     alu_op  = c_ALU_INC;
                     wtr_sel = w_rf;
                     wtr_en  = 1'b1;
                  end
                  c_OP_STR: begin
                     bus_sel   = w_rf;
                     mem_write = 1'b1;
                  end
                  c_OP_LDR: begin
                     mem_read = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_MEMW: mem_read = 1'b1;
         // Memory drives the bus during write-back, so bus_sel stays 0
         ST_WB: begin
            wtr_sel = w_rf;
            wtr_en  = 1'b1;
         end
         ST_HALT: done = 1'b1;
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/wtr_control_unit.sv
`default_nettype none
//============================================================================
// Module   : wtr_control_unit
// Purpose  : Microsequencer of the matrix processor. Fetches 8-bit
//            instructions from a synchronous instruction RAM, holds PC/IR
//            and the memory-wait counter, and sequences the datapath
//            through wtr_cu_decode.
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            cu    - wtr_control_unit_if.master (all handshake/bus signals)
// Params   : IADDR_W - PC / instruction address width
//            MEM_LAT - data-memory read latency in cycles (>= 1)
// Config   : WTR_SINGLE_STEP_EN - park in STEP after every retired
//            instruction until a rising edge on cu.step.
// Revision : 1.0 - initial release
//============================================================================
module wtr_control_unit
   import wtr_cu_pkg::*;
#(
   parameter int IADDR_W = 8,
   parameter int MEM_LAT = 2
)(
   input  logic                   clk,
   input  logic                   rst_n,
   wtr_control_unit_if.master     cu
);

   // MEMW lasts MEM_LAT-1 cycles; the counter is loaded with MEM_LAT-2
   localparam int c_CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;

   state_t               r_state;
   logic [IADDR_W-1:0]   r_pc;
   logic [7:0]           r_ir;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_illegal;
   logic                 w_illegal_hit;

`ifdef WTR_SINGLE_STEP_EN
   logic r_step_d;
   logic w_step_rise;
   assign w_step_rise = cu.step & ~r_step_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_pc      <= '0;
         r_ir      <= '0;
         r_cnt     <= '0;
         r_illegal <= 1'b0;
`ifdef WTR_SINGLE_STEP_EN
         r_step_d  <= 1'b0;
`endif
      end else begin
`ifdef WTR_SINGLE_STEP_EN
         r_step_d <= cu.step;
`endif
         case (r_state)
            ST_IDLE: begin
               if (cu.start) r_state <= ST_FETCH;
            end
            ST_FETCH: r_state <= ST_LATCH;
            ST_LATCH: begin
               r_ir    <= cu.instr;
               r_pc    <= r_pc + IADDR_W'(1);
               r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (w_illegal_hit) begin
                  r_illegal <= 1'b1;
                  r_state   <= c_ST_RETIRE;
               end else begin
                  case (r_ir[7:4])
                     c_OP_LDR: begin
                        if (MEM_LAT == 1) begin
                           r_state <= ST_WB;
                        end else begin
                           r_cnt   <= c_CNT_W'(MEM_LAT - 2);
                           r_state <= ST_MEMW;
                        end
                     end
                     c_OP_JMPNZ: r_state <= ST_TFETCH;
                     c_OP_END:   r_state <= ST_HALT;
                     default:    r_state <= c_ST_RETIRE;
                  endcase
               end
            end
            ST_MEMW: begin
               if (r_cnt == '0) r_state <= ST_WB;
               else             r_cnt   <= r_cnt - c_CNT_W'(1);
            end
            ST_WB:     r_state <= c_ST_RETIRE;
            ST_TFETCH: r_state <= ST_TLATCH;
            ST_TLATCH: begin
               // Jump taken when the ALU result is non-zero; otherwise skip the target byte
               if (!cu.z_flag) r_pc <= IADDR_W'(cu.instr);
               else            r_pc <= r_pc + IADDR_W'(1);
               r_state <= c_ST_RETIRE;
            end
            ST_HALT: begin
               // Restart requires start to drop first
               if (!cu.start) begin
                  r_state <= ST_IDLE;
                  r_pc    <= '0;
               end
            end
`ifdef WTR_SINGLE_STEP_EN
            ST_STEP: begin
               if (w_step_rise) r_state <= ST_FETCH;
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cu.iram_addr = r_pc;
   assign cu.illegal   = r_illegal;

   wtr_cu_decode u_decode (
      .state       (r_state),
      .ir          (r_ir),
      .wtr_sel     (cu.WTR_sel),
      .wtr_en      (cu.WTR_en),
      .bus_sel     (cu.bus_sel),
      .alu_op      (cu.alu_op),
      .mem_read    (cu.mem_read),
      .mem_write   (cu.mem_write),
      .done        (cu.done),
      .illegal_hit (w_illegal_hit)
   );

endmodule
`default_nettype wire

// File: doc/wtr_control_unit.md
Name: wtr_control_unit

Overview:
- Microsequencer of the matrix processor. Fetches 8-bit instructions from instruction RAM, decodes them, and sequences datapath control.
- Produces WTR_sel/WTR_en, which directly feed the write-to-register decoder (one-hot register write enables). Also produces bus read select, ALU op, data-memory strobes and done.
- Sits upstream of the WTR decoder and the bus multiplexer.

Parameters:
- IADDR_W, 8, instruction RAM address width (PC width).
- MEM_LAT, 2, data-memory read latency in cycles (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; sampled in IDLE, begins execution at PC=0.
- z_flag  input  1  ALU zero flag, sampled in JMP states.
- instr  input  8  instruction RAM read data (sync RAM, 1-cycle latency).
- iram_addr  output  IADDR_W  instruction RAM address (= PC).
- WTR_sel  output  5  register write select (1..14; 0 = none).
- WTR_en  output  1  register write enable.
- bus_sel  output  5  register driven onto bus (same codes as WTR_sel).
- alu_op  output  3  0 pass, 1 add, 2 mul, 3 inc.
- mem_read  output  1  data-memory read strobe.
- mem_write  output  1  data-memory write strobe.
- done  output  1  high in HALT.
- illegal  output  1  sticky; set on bad register field.

Behaviour:
- Register codes (fixed): N=1, M=2, P=3, R1=4, ROW=5, COL=6, CURR=7, SUM=8, STA=9, STB=10, STC=11, A=12, B=13, R=14.
- Instruction: opcode=instr[7:4], rf=instr[3:0].
- Opcodes: 0 NOP; 1 LDR rf<-mem; 2 STR mem<-rf; 3 MVR R<-rf; 4 MVT rf<-R; 5 ADD R<-R+rf; 6 MUL R<-R*rf; 7 INC rf<-rf+1; 8 JMPNZ (next byte = target); F END; others = NOP.
- States: IDLE, FETCH, LATCH, EXEC, MEMW, WB, TFETCH, TLATCH, HALT.
- Reset: state=IDLE, PC=0, IR=0, illegal=0. All outputs 0 except iram_addr=0.
- IDLE: if start, go to FETCH.
- FETCH: iram_addr=PC. Next state is LATCH.
- LATCH: IR<=instr, PC<=PC+1 (wraps mod 2^IADDR_W). Next state is EXEC.
- EXEC, by opcode:
  - NOP: go to FETCH.
  - MVR/ADD/MUL: bus_sel=rf, WTR_sel=14, WTR_en=1, alu_op=0/1/2. Go to FETCH.
  - MVT: bus_sel=14, WTR_sel=rf, WTR_en=1. Go to FETCH.
  - INC: bus_sel=rf, alu_op=3, WTR_sel=rf, WTR_en=1. Go to FETCH.
  - STR: bus_sel=rf, mem_write=1 for one cycle. Go to FETCH.
  - LDR: mem_read=1. Go to MEMW.
  - JMPNZ: go to TFETCH.
  - END: go to HALT.
- MEMW: mem_read held; stays MEM_LAT-1 cycles (counter), then WB. With MEM_LAT=1, MEMW lasts 0 cycles and EXEC goes directly to WB.
- WB: WTR_sel=rf, WTR_en=1, bus_sel=0 (memory drives bus). Go to FETCH.
- TFETCH: iram_addr=PC. Go to TLATCH.
- TLATCH: if z_flag=0, PC<=instr; else PC<=PC+1. Go to FETCH.
- HALT: done=1. On start=0 go to IDLE, with PC<=0.
- Instruction latency: 3 cycles for NOP/ALU/MOV/STR; 4+MEM_LAT-1 for LDR; 5 for JMPNZ (including FETCH/LATCH).
- Illegal register field: rf=0 or rf=15 for opcodes 1–7 sets illegal and suppresses WTR_en, mem_write and mem_read; the instruction then behaves as NOP.
- WTR_en is never high outside EXEC/WB.
- WTR_en and mem_write are never high in the same cycle.
- Reset mid-instruction: returns to IDLE immediately. No partial write completes after rst_n falls.
- start held high through HALT does not restart; it must drop first.

Optional Feature:
- Macro: WTR_SINGLE_STEP_EN.
- With the macro: adds input step (1 bit) and state STEP. After each instruction retires (the cycle that would enter FETCH), the FSM enters STEP and waits for a step rising edge (step edge-detected internally), then proceeds to FETCH. END still goes to HALT.
- Without the macro: no step port, no STEP state; instructions issue back-to-back.

Decomposition:
- Package wtr_cu_pkg: opcode constants, register-code constants (1..14), alu_op constants, state enum.
- One combinational sub-module, wtr_cu_decode: maps (state, IR) to the control word (WTR_sel, WTR_en, bus_sel, alu_op, mem_read, mem_write, illegal_hit).
- Top holds the FSM, PC, IR and the MEMW counter.

Test Plan:
- Reset then start=1 with program {0x3C, 0xF0} (MVR A; END) -> cycle 3: bus_sel=12, WTR_sel=14, WTR_en=1; then done=1 with PC=2.
- LDR N (0x11), MEM_LAT=2 -> mem_read high 2 cycles, then one WB cycle with WTR_sel=1, WTR_en=1; total 5 cycles.
- JMPNZ (0x80, 0x05): z_flag=0 -> next iram_addr=5; z_flag=1 -> next iram_addr=2.
- Illegal 0x70 and 0x2F -> illegal=1 (sticky), no WTR_en/mem_write pulse, execution continues at next PC.
- rst_n low during MEMW of LDR -> outputs 0 within the same cycle, state IDLE, no WB pulse after release.
- PC wrap: IADDR_W=8, NOP at 0xFF -> next fetch at iram_addr=0x00. With WTR_SINGLE_STEP_EN, no fetch occurs until a step pulse.
